pipemem_ctrl: RTL

MEM-stage controller of the five-stage pipeline: the consumer end of the EX/MEM pipeline register. It turns the registered memory-stage control and data (mwreg, mm2reg, mwmem, malu, mb, mrn) into handshaked accesses on a multi-cycle data-memory bus. It stalls the upstream stages while an access is outstanding, and contains the MEM/WB register feeding write-back.

---
 rtl/pipemem_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipemem_ctrl.sv
// MEM-stage controller: turns EX/MEM memory control into handshaked data-memory bus accesses,
// stalls upstream while an access is outstanding, and holds the MEM/WB register. Option: MEM_TIMEOUT_EN.
module pipemem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn,
    output logic        misalign,
    output logic        mem_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic access;
    logic aligned;
    logic issue;
    logic finish;
    logic tmo;

    assign access  = mwmem | mm2reg;
    assign aligned = (malu[1:0] == 2'b00);
    assign issue   = (state == IDLE) && access && aligned;
    assign finish  = (state == BUSY) && (dmem_ack || tmo);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err;

    // An ack in the timeout cycle takes priority, so tmo requires !dmem_ack.
    assign tmo     = (state == BUSY) && !dmem_ack && (wait_cnt == 8'(TIMEOUT - 1));
    assign mem_err = err;

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= 8'd0;
            err      <= 1'b0;
        end else begin
            if (state == IDLE)
                wait_cnt <= 8'd0;
            else if (!dmem_ack)
                wait_cnt <= wait_cnt + 8'd1;
            if (tmo)
                err <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = (TIMEOUT != 0);
    assign tmo        = 1'b0;
    assign mem_err    = 1'b0;
`endif

    // Next state plus the combinational stall/misalign outputs, forced low during reset.
    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        misalign  = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (access && aligned) begin
                        mem_stall = 1'b1;
                        state_nxt = BUSY;
                    end else if (access) begin
                        misalign = 1'b1;
                    end
                end
                BUSY: begin
                    if (dmem_ack || tmo)
                        state_nxt = IDLE;
                    else
                        mem_stall = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Bus request register: loaded on issue, held stable until ack or timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mwmem;
                dmem_addr  <= {malu[31:2], 2'b00};
                dmem_wdata <= mb;
            end else if (finish) begin
                dmem_req <= 1'b0;
            end
        end
    end

    // MEM/WB register: bubbles on stall or misalign; a timed-out access retires without write-back.
    always_ff @(posedge clock) begin
        if (reset || mem_stall || misalign) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wmo    <= 32'd0;
            walu   <= 32'd0;
            wrn    <= 5'd0;
        end else begin
            wwreg  <= mwreg & ~tmo;
            wm2reg <= mm2reg & ~tmo;
            wmo    <= ((state == BUSY) && dmem_ack && !dmem_we) ? dmem_rdata : 32'd0;
            walu   <= malu;
            wrn    <= mrn;
        end
    end

endmodule
